// File: rtl/rom_port_arb_if.sv
// Request/response channel between a bus master and a rom-style slave port.
// The master modport issues requests and accepts responses; the slave modport is the mirror.
interface rom_port_arb_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        we;
  logic        req_valid;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rdata;

  modport master (
    output addr, wdata, sel, we, req_valid, rsp_ready,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  addr, wdata, sel, we, req_valid, rsp_ready,
    output req_ready, rsp_valid, rdata
  );
endinterface

// File: rtl/rom_port_arb.sv
// Two-master arbiter (m0 = instruction fetch, m1 = data bus) onto one rom port,
// with at most one transaction outstanding on the shared port.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge where
// valid & ready are both 1; the sender holds valid and payload stable until then,
// and ready may depend combinationally on valid.
module rom_port_arb #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rom_port_arb_if.slave         m0,
    rom_port_arb_if.slave         m1,
    rom_port_arb_if.master        s,
    output logic [1:0]            dbg_state,
    output logic                  dbg_owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_served;

    logic   gnt_any;
    logic   gnt_idx;
    logic   cur;
    logic   cur_valid;
    logic   fwd;
    logic   rsp_phase;

    // Grant is only consulted in IDLE; REQ and RSP use the latched owner.
    always_comb begin
        gnt_any = m0.req_valid | m1.req_valid;
        gnt_idx = 1'b0;
        if (m0.req_valid && m1.req_valid) begin
            gnt_idx = (ROUND_ROBIN != 0) ? ~last_served : 1'b0;
        end else begin
            gnt_idx = m1.req_valid;
        end
    end

    always_comb begin
        cur       = (state == REQ) ? owner : gnt_idx;
        cur_valid = cur ? m1.req_valid : m0.req_valid;
        fwd       = rst_n && (((state == IDLE) && gnt_any) || (state == REQ));
        rsp_phase = rst_n && (state == RSP);
    end

    // Request path: forward the selected master, everything else reads as zero.
    always_comb begin
        s.req_valid  = 1'b0;
        s.addr       = 32'h0;
        s.wdata      = 32'h0;
        s.sel        = 4'h0;
        s.we         = 1'b0;
        m0.req_ready = 1'b0;
        m1.req_ready = 1'b0;
        if (fwd) begin
            s.req_valid = cur_valid;
            if (cur) begin
                s.addr       = m1.addr;
                s.wdata      = m1.wdata;
                s.sel        = m1.sel;
                s.we         = m1.we;
                m1.req_ready = s.req_ready;
            end else begin
                s.addr       = m0.addr;
                s.wdata      = m0.wdata;
                s.sel        = m0.sel;
                s.we         = m0.we;
                m0.req_ready = s.req_ready;
            end
        end
    end

    // Response path: only the owner sees the rom response, and only in RSP.
    always_comb begin
        m0.rsp_valid = 1'b0;
        m1.rsp_valid = 1'b0;
        m0.rdata     = 32'h0;
        m1.rdata     = 32'h0;
        s.rsp_ready  = 1'b0;
        if (rsp_phase) begin
            if (owner) begin
                m1.rsp_valid = s.rsp_valid;
                m1.rdata     = s.rdata;
                s.rsp_ready  = m1.rsp_ready;
            end else begin
                m0.rsp_valid = s.rsp_valid;
                m0.rdata     = s.rdata;
                s.rsp_ready  = m0.rsp_ready;
            end
        end
    end

    // last_served resets to m1 so that m0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        owner <= gnt_idx;
                        state <= s.req_ready ? RSP : REQ;
                    end
                end
                REQ: begin
                    if (s.req_valid && s.req_ready) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (s.rsp_valid && s.rsp_ready) begin
                        state       <= IDLE;
                        last_served <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;
    assign dbg_owner = owner;

endmodule

// File: tb/tb_rom_port_arb.sv
// Directed bench for rom_port_arb: a round-robin instance carries most scenarios,
// a fixed-priority instance covers the tie behaviour with ROUND_ROBIN = 0.
module tb_rom_port_arb;

  logic clk;
  logic rst_n;
  logic [1:0] a_state;
  logic       a_owner;
  logic [1:0] b_state;
  logic       b_owner;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  rom_port_arb_if a_m0 ();
  rom_port_arb_if a_m1 ();
  rom_port_arb_if a_s ();
  rom_port_arb_if b_m0 ();
  rom_port_arb_if b_m1 ();
  rom_port_arb_if b_s ();

  rom_port_arb #(.ROUND_ROBIN(1)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (a_m0.slave),
    .m1        (a_m1.slave),
    .s         (a_s.master),
    .dbg_state (a_state),
    .dbg_owner (a_owner)
  );

  rom_port_arb #(.ROUND_ROBIN(0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (b_m0.slave),
    .m1        (b_m1.slave),
    .s         (b_s.master),
    .dbg_state (b_state),
    .dbg_owner (b_owner)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    #2;
  endtask

  task automatic idle_all;
    a_m0.addr = 0; a_m0.wdata = 0; a_m0.sel = 0; a_m0.we = 0; a_m0.req_valid = 0; a_m0.rsp_ready = 0;
    a_m1.addr = 0; a_m1.wdata = 0; a_m1.sel = 0; a_m1.we = 0; a_m1.req_valid = 0; a_m1.rsp_ready = 0;
    b_m0.addr = 0; b_m0.wdata = 0; b_m0.sel = 0; b_m0.we = 0; b_m0.req_valid = 0; b_m0.rsp_ready = 0;
    b_m1.addr = 0; b_m1.wdata = 0; b_m1.sel = 0; b_m1.we = 0; b_m1.req_valid = 0; b_m1.rsp_ready = 0;
    a_s.req_ready = 0; a_s.rsp_valid = 0; a_s.rdata = 0;
    b_s.req_ready = 0; b_s.rsp_valid = 0; b_s.rdata = 0;
  endtask

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] e;
    checks   = 0;
    failures = 0;
    idle_all();
    rst_n = 1'b0;

    // reset: outputs forced low even with a master requesting
    a_m0.req_valid = 1; a_m0.addr = 32'h40; a_s.req_ready = 1;
    tick();
    look();
    chk("rst_state", a_state, 0);
    chk("rst_s_req_valid", a_s.req_valid, 0);
    chk("rst_m0_req_ready", a_m0.req_ready, 0);
    chk("rst_s_addr", a_s.addr, 0);
    chk("rst_s_rsp_ready", a_s.rsp_ready, 0);
    tick();
    a_m0.req_valid = 0; a_m0.addr = 0;
    rst_n = 1'b1;
    look();
    chk("post_rst_state", a_state, 0);

    // round-robin tie: m0, m1, m0, m1
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    a_m0.req_valid = 1; a_m0.addr = 32'hA0; a_m0.sel = 4'hF; a_m0.rsp_ready = 1;
    a_m1.req_valid = 1; a_m1.addr = 32'hB0; a_m1.sel = 4'hF; a_m1.rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      look();
      chk("rr_state_idle", a_state, 0);
      chk("rr_m0_req_ready", a_m0.req_ready, {31'b0, ~e[0]});
      chk("rr_m1_req_ready", a_m1.req_ready, e);
      chk("rr_s_addr", a_s.addr, e[0] ? 32'hB0 : 32'hA0);
      tick();
      a_s.rsp_valid = 1; a_s.rdata = 32'h5000 + i;
      look();
      chk("rr_state_rsp", a_state, 2);
      chk("rr_s_req_valid_rsp", a_s.req_valid, 0);
      chk("rr_owner_rsp_valid", e[0] ? a_m1.rsp_valid : a_m0.rsp_valid, 1);
      chk("rr_other_rsp_valid", e[0] ? a_m0.rsp_valid : a_m1.rsp_valid, 0);
      chk("rr_owner_data", e[0] ? a_m1.rdata : a_m0.rdata, 32'h5000 + i);
      tick();
      a_s.rsp_valid = 0; a_s.rdata = 0;
    end
    chk("rr_queue_drained", exp_q.size(), 0);

    // single read by m0
    a_m1.req_valid = 0; a_m1.addr = 0;
    a_m0.addr = 32'h100;
    look();
    chk("rd_s_addr", a_s.addr, 32'h100);
    chk("rd_s_req_valid", a_s.req_valid, 1);
    chk("rd_s_we", a_s.we, 0);
    chk("rd_m0_req_ready", a_m0.req_ready, 1);
    tick();
    a_m0.req_valid = 0;
    a_s.rsp_valid = 1; a_s.rdata = 32'hDEADBEEF;
    look();
    chk("rd_m0_rsp_valid", a_m0.rsp_valid, 1);
    chk("rd_m0_data", a_m0.rdata, 32'hDEADBEEF);
    chk("rd_m1_rsp_valid", a_m1.rsp_valid, 0);
    chk("rd_m1_data", a_m1.rdata, 0);
    chk("rd_s_rsp_ready", a_s.rsp_ready, 1);
    tick();
    a_s.rsp_valid = 0; a_s.rdata = 0;
    look();
    chk("rd_back_idle", a_state, 0);

    // backpressure: m1 write stalled 3 cycles, m0 arrives late
    a_s.req_ready = 0;
    a_m1.req_valid = 1; a_m1.addr = 32'h200; a_m1.we = 1; a_m1.wdata = 32'hCAFEF00D; a_m1.sel = 4'h3;
    look();
    chk("bp_s_req_valid", a_s.req_valid, 1);
    chk("bp_m1_req_ready_low", a_m1.req_ready, 0);
    tick();
    look();
    chk("bp_state_req", a_state, 1);
    tick();
    a_m0.req_valid = 1; a_m0.addr = 32'h300;
    look();
    chk("bp_still_m1_addr", a_s.addr, 32'h200);
    tick();
    a_s.req_ready = 1;
    look();
    chk("bp_s_addr", a_s.addr, 32'h200);
    chk("bp_s_we", a_s.we, 1);
    chk("bp_s_data", a_s.wdata, 32'hCAFEF00D);
    chk("bp_s_sel", a_s.sel, 4'h3);
    chk("bp_m1_req_ready", a_m1.req_ready, 1);
    chk("bp_m0_req_ready", a_m0.req_ready, 0);
    tick();
    a_m1.req_valid = 0; a_m1.we = 0; a_m1.wdata = 0; a_m1.sel = 0;
    look();
    chk("wr_waits_rsp", a_state, 2);
    chk("bp_m0_blocked", a_m0.req_ready, 0);
    chk("bp_s_req_valid_rsp", a_s.req_valid, 0);
    tick();
    a_s.rsp_valid = 1; a_s.rdata = 32'h11111111;
    look();
    chk("bp_m1_rsp_valid", a_m1.rsp_valid, 1);
    chk("bp_m0_rsp_valid", a_m0.rsp_valid, 0);
    tick();
    a_s.rsp_valid = 0;
    look();
    chk("bp_m0_now_served", a_m0.req_ready, 1);
    chk("bp_m0_addr", a_s.addr, 32'h300);

    // response stall on m0
    tick();
    a_m0.req_valid = 0; a_m0.rsp_ready = 0;
    a_s.rsp_valid = 1; a_s.rdata = 32'h22222222;
    look();
    chk("st_s_rsp_ready_0", a_s.rsp_ready, 0);
    chk("st_m0_rsp_valid", a_m0.rsp_valid, 1);
    tick();
    look();
    chk("st_state_hold", a_state, 2);
    chk("st_s_rsp_ready_1", a_s.rsp_ready, 0);
    tick();
    a_m0.rsp_ready = 1;
    look();
    chk("st_s_rsp_ready_rise", a_s.rsp_ready, 1);
    tick();
    look();
    chk("st_done_idle", a_state, 0);
    chk("ign_m0_rsp_valid", a_m0.rsp_valid, 0);
    chk("ign_m1_rsp_valid", a_m1.rsp_valid, 0);
    chk("ign_s_rsp_ready", a_s.rsp_ready, 0);
    a_s.rsp_valid = 0;

    // reset in RSP aborts m1's transaction
    a_m1.req_valid = 1; a_m1.addr = 32'hE0; a_m1.rsp_ready = 1;
    look();
    chk("ra_m1_lone_grant", a_m1.req_ready, 1);
    tick();
    a_m1.req_valid = 0;
    a_s.rsp_valid = 1; a_s.rdata = 32'h33333333;
    look();
    chk("ra_m1_rsp_valid", a_m1.rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ra_state", a_state, 0);
    chk("ra_m1_rsp_valid_0", a_m1.rsp_valid, 0);
    chk("ra_m1_data_0", a_m1.rdata, 0);
    chk("ra_s_rsp_ready", a_s.rsp_ready, 0);
    tick();
    a_m0.req_valid = 1; a_m0.addr = 32'hA0;
    a_m1.req_valid = 1; a_m1.addr = 32'hB0;
    #1;
    chk("ra_s_req_valid_rst", a_s.req_valid, 0);
    tick();
    rst_n = 1'b1;
    look();
    chk("ra_no_rsp_m0", a_m0.rsp_valid, 0);
    chk("ra_no_rsp_m1", a_m1.rsp_valid, 0);
    chk("ra_tie_m0", a_m0.req_ready, 1);
    chk("ra_tie_m1", a_m1.req_ready, 0);
    chk("ra_tie_addr", a_s.addr, 32'hA0);
    a_s.rsp_valid = 0;
    tick();
    a_m0.req_valid = 0; a_m1.req_valid = 0;
    a_s.rsp_valid = 1; a_s.rdata = 32'h44444444;
    look();
    chk("ra_m0_served_data", a_m0.rdata, 32'h44444444);
    tick();
    a_s.rsp_valid = 0;

    // fixed priority: m0 wins every tie
    b_s.req_ready = 1;
    b_m0.req_valid = 1; b_m0.addr = 32'hC0; b_m0.rsp_ready = 1;
    b_m1.req_valid = 1; b_m1.addr = 32'hD0; b_m1.rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("fp_m0_req_ready", b_m0.req_ready, 1);
      chk("fp_m1_req_ready", b_m1.req_ready, 0);
      chk("fp_s_addr", b_s.addr, 32'hC0);
      tick();
      b_s.rsp_valid = 1; b_s.rdata = 32'h700 + i;
      look();
      chk("fp_m1_req_ready_rsp", b_m1.req_ready, 0);
      chk("fp_m0_rsp_valid", b_m0.rsp_valid, 1);
      chk("fp_m0_data", b_m0.rdata, 32'h700 + i);
      tick();
      b_s.rsp_valid = 0;
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
